ocimem_access_arbiter: RTL

- Sysclk-domain controller that shares the single-port on-chip debug RAM (OCI memory) between two requesters:
  - the JTAG debug slave's decoded action strobes (take_action_ocimem_a/b, take_no_action_ocimem_a carrying jdo);
  - the CPU's debug-memory slave port.
- Sequences each RAM access (address load, write, read with 1-cycle RAM latency) and arbitrates round-robin on conflict.
- Returns JTAG read/write data in MonDReg and CPU read data on cpu_readdata.

---
 rtl/ocimem_access_arbiter_if.sv | 29 ++
 rtl/ocimem_access_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ocimem_access_arbiter_if.sv
// CPU debug-memory slave port and OCI RAM port of the OCI memory arbiter.
// The arbiter takes the slave view; the CPU/RAM side takes the master view.
interface ocimem_access_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] cpu_address;
    logic              cpu_read;
    logic              cpu_write;
    logic [DATA_W-1:0] cpu_writedata;
    logic              cpu_waitrequest;
    logic [DATA_W-1:0] cpu_readdata;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  cpu_address, cpu_read, cpu_write, cpu_writedata, ram_rdata,
        output cpu_waitrequest, cpu_readdata, ram_addr, ram_wdata, ram_we, ram_re
    );

    modport master (
        output cpu_address, cpu_read, cpu_write, cpu_writedata, ram_rdata,
        input  cpu_waitrequest, cpu_readdata, ram_addr, ram_wdata, ram_we, ram_re
    );
endinterface

// File: rtl/ocimem_access_arbiter.sv
// Shares the single-port OCI debug RAM between JTAG action strobes and the
// CPU debug-memory port, one access in flight, round-robin on conflict.
//
// state   | meaning
// IDLE    | no access in flight; arbitrate between JTAG pending op and CPU
// J_ISSUE | drive RAM with JTAG address; write completes here, read issues
// J_CAPT  | capture RAM read data into MonDReg, advance JTAG address
// C_ISSUE | drive RAM with CPU address; write completes here, read issues
// C_CAPT  | return RAM read data to the CPU
module ocimem_access_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [37:0]               jdo,
    input  logic                      take_action_ocimem_a,
    input  logic                      take_action_ocimem_b,
    input  logic                      take_no_action_ocimem_a,
    ocimem_access_arbiter_if.slave    bus,
    output logic [DATA_W-1:0]         MonDReg,
    output logic                      jtag_busy,
    output logic                      jtag_overrun
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        J_ISSUE = 3'd1,
        J_CAPT  = 3'd2,
        C_ISSUE = 3'd3,
        C_CAPT  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t              state, state_d;
    logic                last_grant_jtag;
    logic                cpu_done, cpu_done_d;
    logic [DATA_W-1:0]   cpu_rdata_q;

    logic [ADDR_W-1:0]   jaddr;
    logic                pend_valid;
    logic                pend_wr;
    logic [DATA_W-1:0]   pend_data;

    logic                grant_j, grant_c, j_done;
    logic                cpu_req, any_strobe;
    logic [ADDR_W-1:0]   ram_addr_c;
    logic [DATA_W-1:0]   ram_wdata_c;
    logic                ram_we_c, ram_re_c;
    logic                unused_jdo;

    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};
    assign cpu_req    = bus.cpu_read | bus.cpu_write;
    assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

    assign jtag_busy           = pend_valid;
    assign bus.cpu_waitrequest = cpu_req & ~cpu_done;
    // Read data is forwarded straight from the RAM in the completion cycle.
    assign bus.cpu_readdata    = (state == C_CAPT) ? bus.ram_rdata : cpu_rdata_q;
    assign bus.ram_addr        = ram_addr_c;
    assign bus.ram_wdata       = ram_wdata_c;
    assign bus.ram_we          = ram_we_c;
    assign bus.ram_re          = ram_re_c;

    always_comb begin
        state_d     = state;
        ram_addr_c  = '0;
        ram_wdata_c = '0;
        ram_we_c    = 1'b0;
        ram_re_c    = 1'b0;
        grant_j     = 1'b0;
        grant_c     = 1'b0;
        cpu_done_d  = 1'b0;
        j_done      = 1'b0;
        case (state)
            IDLE: begin
                if (pend_valid && (!cpu_req || !last_grant_jtag)) begin
                    grant_j = 1'b1;
                    state_d = J_ISSUE;
                end else if (cpu_req) begin
                    grant_c    = 1'b1;
                    cpu_done_d = ~bus.cpu_read;
                    state_d    = C_ISSUE;
                end
            end
            J_ISSUE: begin
                ram_addr_c = jaddr;
                if (pend_wr) begin
                    ram_we_c    = 1'b1;
                    ram_wdata_c = pend_data;
                    j_done      = 1'b1;
                    state_d     = IDLE;
                end else begin
                    ram_re_c = 1'b1;
                    state_d  = J_CAPT;
                end
            end
            J_CAPT: begin
                j_done  = 1'b1;
                state_d = IDLE;
            end
            C_ISSUE: begin
                ram_addr_c = bus.cpu_address;
                if (bus.cpu_read) begin
                    ram_re_c   = 1'b1;
                    cpu_done_d = 1'b1;
                    state_d    = C_CAPT;
                end else begin
                    ram_we_c    = 1'b1;
                    ram_wdata_c = bus.cpu_writedata;
                    state_d     = IDLE;
                end
            end
            C_CAPT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            last_grant_jtag <= 1'b0;
            cpu_done        <= 1'b0;
            cpu_rdata_q     <= '0;
            MonDReg         <= '0;
        end else begin
            state    <= state_d;
            cpu_done <= cpu_done_d;
            if (grant_j)
                last_grant_jtag <= 1'b1;
            else if (grant_c)
                last_grant_jtag <= 1'b0;
            if (state == J_ISSUE && pend_wr)
                MonDReg <= pend_data;
            else if (state == J_CAPT)
                MonDReg <= bus.ram_rdata;
            if (state == C_CAPT)
                cpu_rdata_q <= bus.ram_rdata;
        end
    end

    // Strobe priority b > no_action_a > action_a; losers are silently dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jaddr        <= '0;
            pend_valid   <= 1'b0;
            pend_wr      <= 1'b0;
            pend_data    <= '0;
            jtag_overrun <= 1'b0;
        end else begin
            if (j_done) begin
                pend_valid <= 1'b0;
                jaddr      <= jaddr + ADDR_ONE;
            end
            if (any_strobe) begin
                if (pend_valid) begin
                    jtag_overrun <= 1'b1;
                end else if (take_action_ocimem_b) begin
                    pend_valid <= 1'b1;
                    pend_wr    <= 1'b1;
                    pend_data  <= jdo[34:3];
                end else if (take_no_action_ocimem_a) begin
                    pend_valid <= 1'b1;
                    pend_wr    <= 1'b0;
                end else begin
                    jaddr <= jdo[17 +: ADDR_W];
                    if (jdo[34]) begin
                        pend_valid <= 1'b1;
                        pend_wr    <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
